// File: rtl/elixirchip_es1_spu_op_sub_flags.sv
// Subtract-with-carry (s_data0 + ~s_data1 + s_carry) producing carry/msb-carry/sign flags, LATENCY-deep pipeline.
// Define ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN to add the m_zero output.
module elixirchip_es1_spu_op_sub_flags #(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned DATA_BITS  = 8,
    parameter type         data_t     = logic [DATA_BITS-1:0],
    parameter data_t       CLEAR_DATA = '0,
    parameter string       DEVICE     = "RTL",
    parameter string       SIMULATION = "false",
    parameter string       DEBUG      = "false"
) (
    input  logic  reset,
    input  logic  clk,
    input  logic  cke,
    input  logic  s_carry,
    input  data_t s_data0,
    input  data_t s_data1,
    input  logic  s_clear,
    input  logic  s_valid,
    output data_t m_data,
    output logic  m_carry,
    output logic  m_msb_c,
    output logic  m_sign,
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
    output logic  m_zero,
`endif
    output data_t m_data0,
    output data_t m_data1,
    output logic  m_clear,
    output logic  m_valid
);

    localparam int unsigned W  = DATA_BITS;
    localparam int unsigned WS = DATA_BITS + 1;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
    localparam int unsigned NF = 4;
`else
    localparam int unsigned NF = 3;
`endif

    // Implementation-selection parameters have no functional effect.
    if (DEVICE == "" && SIMULATION == "" && DEBUG == "") begin : g_param_unused
    end

    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [W-1:0]  w_b_n;
    logic [WS-1:0] w_sum;
    logic [W-1:0]  w_res;
    logic          w_msb_c;
    logic [NF-1:0] w_flags;
    logic [W-1:0]  w_clear_data;

    logic [W-1:0]  w_m_data;
    logic [W-1:0]  w_m_d0;
    logic [W-1:0]  w_m_d1;
    logic [NF-1:0] w_m_flags;
    logic          w_m_clear;
    logic          w_m_valid;

    // Single (DATA_BITS+1)-wide addition; every flag is taken from it.
    always_comb begin
        w_a     = W'(s_data0);
        w_b     = W'(s_data1);
        w_b_n   = ~w_b;
        w_sum   = {1'b0, w_a} + {1'b0, w_b_n} + WS'(s_carry);
        w_res   = w_sum[W-1:0];
        w_msb_c = w_sum[W-1] ^ w_a[W-1] ^ w_b_n[W-1];
    end

    assign w_clear_data = W'(CLEAR_DATA);

    // Flag vector: [0]=carry, [1]=msb carry, [2]=sign, [3]=zero (optional).
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
    assign w_flags = {(w_res == '0), w_res[W-1], w_msb_c, w_sum[W]};
`else
    assign w_flags = {w_res[W-1], w_msb_c, w_sum[W]};
`endif

    if (LATENCY == 0) begin : g_comb
        assign w_m_data  = s_clear ? w_clear_data : w_res;
        assign w_m_d0    = s_clear ? w_clear_data : w_a;
        assign w_m_d1    = s_clear ? w_clear_data : w_b;
        assign w_m_flags = s_clear ? '0 : w_flags;
        assign w_m_clear = s_clear;
        assign w_m_valid = s_valid;
    end else begin : g_pipe
        logic [W-1:0]  r_data  [1:LATENCY];
        logic [W-1:0]  r_d0    [1:LATENCY];
        logic [W-1:0]  r_d1    [1:LATENCY];
        logic [NF-1:0] r_flags [1:LATENCY];
        logic          r_clear [1:LATENCY];
        logic          r_valid [1:LATENCY];

        logic [W-1:0]  w_in_data  [1:LATENCY];
        logic [W-1:0]  w_in_d0    [1:LATENCY];
        logic [W-1:0]  w_in_d1    [1:LATENCY];
        logic [NF-1:0] w_in_flags [1:LATENCY];
        logic          w_in_clear [1:LATENCY];
        logic          w_in_valid [1:LATENCY];

        // Stage 1 takes the computed result; later stages take the previous stage.
        always_comb begin
            w_in_data[1]  = w_res;
            w_in_d0[1]    = w_a;
            w_in_d1[1]    = w_b;
            w_in_flags[1] = w_flags;
            w_in_clear[1] = s_clear;
            w_in_valid[1] = s_valid;
            for (int i = 2; i <= int'(LATENCY); i++) begin
                w_in_data[i]  = r_data[i-1];
                w_in_d0[i]    = r_d0[i-1];
                w_in_d1[i]    = r_d1[i-1];
                w_in_flags[i] = r_flags[i-1];
                w_in_clear[i] = r_clear[i-1];
                w_in_valid[i] = r_valid[i-1];
            end
        end

        // Clear beats valid; an invalid entry holds payload while clear/valid still advance.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 1; i <= int'(LATENCY); i++) begin
                    r_data[i]  <= w_clear_data;
                    r_d0[i]    <= w_clear_data;
                    r_d1[i]    <= w_clear_data;
                    r_flags[i] <= '0;
                    r_clear[i] <= 1'b0;
                    r_valid[i] <= 1'b0;
                end
            end else if (cke) begin
                for (int i = 1; i <= int'(LATENCY); i++) begin
                    r_clear[i] <= w_in_clear[i];
                    r_valid[i] <= w_in_valid[i];
                    if (w_in_clear[i]) begin
                        r_data[i]  <= w_clear_data;
                        r_d0[i]    <= w_clear_data;
                        r_d1[i]    <= w_clear_data;
                        r_flags[i] <= '0;
                    end else if (w_in_valid[i]) begin
                        r_data[i]  <= w_in_data[i];
                        r_d0[i]    <= w_in_d0[i];
                        r_d1[i]    <= w_in_d1[i];
                        r_flags[i] <= w_in_flags[i];
                    end
                end
            end
        end

        assign w_m_data  = r_data[LATENCY];
        assign w_m_d0    = r_d0[LATENCY];
        assign w_m_d1    = r_d1[LATENCY];
        assign w_m_flags = r_flags[LATENCY];
        assign w_m_clear = r_clear[LATENCY];
        assign w_m_valid = r_valid[LATENCY];
    end

    assign m_data  = w_m_data;
    assign m_data0 = w_m_d0;
    assign m_data1 = w_m_d1;
    assign m_carry = w_m_flags[0];
    assign m_msb_c = w_m_flags[1];
    assign m_sign  = w_m_flags[2];
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
    assign m_zero  = w_m_flags[3];
`endif
    assign m_clear = w_m_clear;
    assign m_valid = w_m_valid;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sub_flags.sv
// Bench for elixirchip_es1_spu_op_sub_flags: several latency/width builds against a history-based reference model.
module tb_elixirchip_es1_spu_op_sub_flags;

    localparam int NI = 5;
    localparam int unsigned LAT [NI] = '{0, 1, 2, 3, 1};
    localparam int unsigned NB  [NI] = '{8, 8, 8, 1, 1};
    localparam logic [7:0]  CLR [NI] = '{8'd123, 8'd123, 8'h5A, 8'd1, 8'd0};

    typedef struct packed {
        logic       v;
        logic       cl;
        logic       c;
        logic [7:0] d0;
        logic [7:0] d1;
    } smp_t;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       carry;
        logic       msbc;
        logic       sign;
        logic       zero;
        logic       clear;
        logic       valid;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cke;
    logic       s_carry;
    logic       s_clear;
    logic       s_valid;
    logic [7:0] s_d0;
    logic [7:0] s_d1;

    logic [7:0] o_data  [NI];
    logic [7:0] o_d0    [NI];
    logic [7:0] o_d1    [NI];
    logic       o_carry [NI];
    logic       o_msbc  [NI];
    logic       o_sign  [NI];
    logic       o_clear [NI];
    logic       o_valid [NI];
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
    logic       o_zero  [NI];
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit model_on = 1'b0;
    smp_t hist[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned W = NB[g];
        localparam logic [W-1:0] C = W'(CLR[g]);
        logic [W-1:0] d;
        logic [W-1:0] d0;
        logic [W-1:0] d1;

        elixirchip_es1_spu_op_sub_flags #(
            .LATENCY    (LAT[g]),
            .DATA_BITS  (W),
            .CLEAR_DATA (C)
        ) u_dut (
            .reset   (reset),
            .clk     (clk),
            .cke     (cke),
            .s_carry (s_carry),
            .s_data0 (s_d0[W-1:0]),
            .s_data1 (s_d1[W-1:0]),
            .s_clear (s_clear),
            .s_valid (s_valid),
            .m_data  (d),
            .m_carry (o_carry[g]),
            .m_msb_c (o_msbc[g]),
            .m_sign  (o_sign[g]),
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
            .m_zero  (o_zero[g]),
`endif
            .m_data0 (d0),
            .m_data1 (d1),
            .m_clear (o_clear[g]),
            .m_valid (o_valid[g])
        );

        assign o_data[g] = 8'(d);
        assign o_d0[g]   = 8'(d0);
        assign o_d1[g]   = 8'(d1);
    end

    // Reference subtract in plain integer arithmetic; msb carry from signed overflow (msb_c = carry ^ overflow).
    function automatic exp_t sub_ref(int w, smp_t s);
        exp_t e;
        int mask, a, b, r, sa, sb, sr, half;
        bit ovf;
        e    = '0;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        a    = int'(s.d0) & mask;
        b    = int'(s.d1) & mask;
        r    = a - b - 1 + int'(s.c);
        sa   = (a >= half) ? a - (1 << w) : a;
        sb   = (b >= half) ? b - (1 << w) : b;
        sr   = sa - sb - 1 + int'(s.c);
        ovf  = (sr < -half) || (sr > half - 1);
        e.carry = (r >= 0);
        e.data  = 8'(r & mask);
        e.sign  = e.data[w-1];
        e.msbc  = e.carry ^ ovf;
        e.zero  = ((r & mask) == 0);
        e.d0    = 8'(a);
        e.d1    = 8'(b);
        return e;
    endfunction

    // Output = newest accepted (valid or clear) sample at least LATENCY ticks old.
    function automatic exp_t model(int g);
        exp_t e;
        smp_t cur;
        int n, l;
        e      = '0;
        e.data = CLR[g];
        e.d0   = CLR[g];
        e.d1   = CLR[g];
        l      = int'(LAT[g]);
        if (l == 0) begin
            cur.v  = s_valid;
            cur.cl = s_clear;
            cur.c  = s_carry;
            cur.d0 = s_d0;
            cur.d1 = s_d1;
            if (!s_clear) e = sub_ref(int'(NB[g]), cur);
            e.clear = s_clear;
            e.valid = s_valid;
            return e;
        end
        n = hist.size();
        for (int j = n - l; j >= 0; j--) begin
            if (hist[j].cl) break;
            if (hist[j].v) begin
                e = sub_ref(int'(NB[g]), hist[j]);
                break;
            end
        end
        e.clear = 1'b0;
        e.valid = 1'b0;
        if (n >= l) begin
            e.clear = hist[n-l].cl;
            e.valid = hist[n-l].v;
        end
        return e;
    endfunction

    task automatic chk(string nm, int g, logic [7:0] got, logic [7:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s u%0d t=%0t: got %h expected %h", nm, g, $time, got, exp_v);
        end
    endtask

    // Model update on each edge, then compare every instance every cycle.
    always @(posedge clk) begin
        smp_t s;
        exp_t e;
        s.v  = s_valid;
        s.cl = s_clear;
        s.c  = s_carry;
        s.d0 = s_d0;
        s.d1 = s_d1;
        if (reset) begin
            hist.delete();
            model_on = 1'b1;
        end else if (cke) begin
            hist.push_back(s);
        end
        #1;
        if (model_on) begin
            for (int g = 0; g < NI; g++) begin
                e = model(g);
                chk("data",  g, o_data[g],        e.data);
                chk("data0", g, o_d0[g],          e.d0);
                chk("data1", g, o_d1[g],          e.d1);
                chk("carry", g, 8'(o_carry[g]),   8'(e.carry));
                chk("msb_c", g, 8'(o_msbc[g]),    8'(e.msbc));
                chk("sign",  g, 8'(o_sign[g]),    8'(e.sign));
                chk("clear", g, 8'(o_clear[g]),   8'(e.clear));
                chk("valid", g, 8'(o_valid[g]),   8'(e.valid));
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
                chk("zero",  g, 8'(o_zero[g]),    8'(e.zero));
`endif
            end
        end
    end

    task automatic step(logic [7:0] d0, logic [7:0] d1, logic c, logic v, logic cl, logic rst);
        @(negedge clk);
        reset   = rst;
        cke     = 1'b1;
        s_d0    = d0;
        s_d1    = d1;
        s_carry = c;
        s_valid = v;
        s_clear = cl;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        cke     = 1'b1;
        s_carry = 1'b1;
        s_clear = 1'b0;
        s_valid = 1'b0;
        s_d0    = 8'h00;
        s_d1    = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        chk("lit_rst_data",  1, o_data[1], 8'd123);
        chk("lit_rst_valid", 1, 8'(o_valid[1]), 8'd0);
        chk("lit_rst_data2", 2, o_data[2], 8'h5A);

        step(8'h10, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_ff_data",  1, o_data[1], 8'hFF);
        chk("lit_ff_carry", 1, 8'(o_carry[1]), 8'd0);
        chk("lit_ff_msbc",  1, 8'(o_msbc[1]), 8'd0);
        chk("lit_ff_sign",  1, 8'(o_sign[1]), 8'd1);

        step(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_7f_data",  1, o_data[1], 8'h7F);
        chk("lit_7f_carry", 1, 8'(o_carry[1]), 8'd1);
        chk("lit_7f_msbc",  1, 8'(o_msbc[1]), 8'd0);
        chk("lit_7f_slt",   1, 8'(o_sign[1] ^ o_carry[1] ^ o_msbc[1]), 8'd1);

        step(8'h05, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_eq_data",  1, o_data[1], 8'h00);
        chk("lit_eq_carry", 1, 8'(o_carry[1]), 8'd1);
        chk("lit_eq_msbc",  1, 8'(o_msbc[1]), 8'd1);
`ifdef ELIXIRCHIP_ES1_SPU_OP_SUB_FLAGS_ZERO_EN
        chk("lit_eq_zero",  1, 8'(o_zero[1]), 8'd1);
`endif

        step(8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lit_clr_data",  1, o_data[1], 8'd123);
        chk("lit_clr_d0",    1, o_d0[1], 8'd123);
        chk("lit_clr_d1",    1, o_d1[1], 8'd123);
        chk("lit_clr_carry", 1, 8'(o_carry[1]), 8'd0);
        chk("lit_clr_flag",  1, 8'(o_clear[1]), 8'd1);

        step(8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_hold_data",  1, o_data[1], 8'd123);
        chk("lit_hold_valid", 1, 8'(o_valid[1]), 8'd0);

        step(8'h20, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8'h20, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("lit_mrst_data", 2, o_data[2], 8'h5A);
        chk("lit_mrst_valid", 2, 8'(o_valid[2]), 8'd0);
        chk("lit_mrst_data1", 1, o_data[1], 8'd123);

        repeat (3000) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 99) < 2);
            cke     = ($urandom_range(0, 99) < 85);
            s_valid = ($urandom_range(0, 99) < 70);
            s_clear = ($urandom_range(0, 99) < 10);
            s_carry = ($urandom_range(0, 99) < 75) ? 1'b1 : 1'($urandom);
            s_d0    = pick();
            s_d1    = pick();
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
